// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
//   Bundles the sequencer's handshake inputs and datapath control outputs.
//
//   Inputs to the sequencer:
//     run        leave IDLE and start fetching
//     opcode     instr[31:26] from the instruction register
//     mem_ready  memory access completes this cycle
//   Outputs from the sequencer:
//     pc_wr_en, branch_en, pc_src[1:0]    program counter update control
//     ir_wr_en, i_or_d                    instruction register / address select
//     mem_rd_en, mem_wr_en                unified memory strobes
//     reg_wr_en, reg_dest, mem_to_reg     register file write-back control
//     alu_src_a, alu_src_b[1:0]           ALU operand selects
//     alu_opcode[1:0]                     ALU operation class
//     instr_done, halted, illegal_op      status
//     state[3:0]                          current FSM state (debug)
//
//   Modports:
//     slave  - the sequencer itself
//     master - the datapath / environment that drives it
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if;
  logic       run;
  logic [5:0] opcode;
  logic       mem_ready;

  logic       pc_wr_en;
  logic       branch_en;
  logic [1:0] pc_src;
  logic       ir_wr_en;
  logic       i_or_d;
  logic       mem_rd_en;
  logic       mem_wr_en;
  logic       reg_wr_en;
  logic       reg_dest;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_opcode;
  logic       instr_done;
  logic       halted;
  logic       illegal_op;
  logic [3:0] state;

  modport slave (
    input  run, opcode, mem_ready,
    output pc_wr_en, branch_en, pc_src, ir_wr_en, i_or_d, mem_rd_en,
           mem_wr_en, reg_wr_en, reg_dest, mem_to_reg, alu_src_a,
           alu_src_b, alu_opcode, instr_done, halted, illegal_op, state
  );

  modport master (
    output run, opcode, mem_ready,
    input  pc_wr_en, branch_en, pc_src, ir_wr_en, i_or_d, mem_rd_en,
           mem_wr_en, reg_wr_en, reg_dest, mem_to_reg, alu_src_a,
           alu_src_b, alu_opcode, instr_done, halted, illegal_op, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle sequencer for the MIPS datapath. One ALU and one unified
//   memory port are shared across the cycles of each instruction; the FSM
//   retires exactly one instruction per pass through FETCH.
//
//   Ports:
//     clk    in  system clock, rising edge
//     rst_n  in  synchronous active-low reset
//     bus    multicycle_ctrl_if.slave (handshake inputs, control outputs)
//
//   Parameters:
//     MEM_TIMEOUT  wait-cycle limit per memory access (timeout build only)
//
//   Build option:
//     MC_MEM_TIMEOUT_EN  when defined, a memory access that waits
//                        MEM_TIMEOUT cycles without mem_ready halts the FSM
//                        with illegal_op set. When undefined the FSM waits
//                        indefinitely.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.slave   bus
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_MEM_ADDR  = 4'd3;
  localparam logic [3:0] S_MEM_READ  = 4'd4;
  localparam logic [3:0] S_MEM_WB    = 4'd5;
  localparam logic [3:0] S_MEM_WRITE = 4'd6;
  localparam logic [3:0] S_R_EXEC    = 4'd7;
  localparam logic [3:0] S_R_WB      = 4'd8;
  localparam logic [3:0] S_ADDI_EXEC = 4'd9;
  localparam logic [3:0] S_ADDI_WB   = 4'd10;
  localparam logic [3:0] S_BRANCH    = 4'd11;
  localparam logic [3:0] S_JUMP      = 4'd12;
  localparam logic [3:0] S_HALT      = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // A zero limit would make the timeout compare meaningless.
  if (MEM_TIMEOUT < 1) begin : g_bad_timeout
    $error("multicycle_ctrl: MEM_TIMEOUT must be at least 1");
  end

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;

`ifdef MC_MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT) + 1;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             in_mem_state;
  logic             timed_out;

  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                        (state_q == S_MEM_WRITE);
  // The counter holds the number of wait cycles already spent; this cycle
  // would be wait number MEM_TIMEOUT, so give up at the coming edge.
  assign timed_out = in_mem_state && !bus.mem_ready &&
                     (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    // Any state change clears, so entry into a memory state starts at zero.
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (in_mem_state && !bus.mem_ready) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE:      if (bus.run) state_d = S_FETCH;
      S_FETCH:     if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:      state_d = S_R_EXEC;
          OP_ADDI:       state_d = S_ADDI_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_HALT:       state_d = S_HALT;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default: begin
        // Encodings 14-15 are unreachable; treat entry as a fault.
        state_d   = S_HALT;
        illegal_d = 1'b1;
      end
    endcase
`ifdef MC_MEM_TIMEOUT_EN
    if (timed_out) begin
      state_d   = S_HALT;
      illegal_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      illegal_q  <= 1'b0;
`ifdef MC_MEM_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      illegal_q  <= illegal_d;
`ifdef MC_MEM_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode: purely from the state register, plus mem_ready for the
  // write-enables that must only fire on the completing memory cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.pc_wr_en   = 1'b0;
    bus.branch_en  = 1'b0;
    bus.pc_src     = 2'b00;
    bus.ir_wr_en   = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.mem_rd_en  = 1'b0;
    bus.mem_wr_en  = 1'b0;
    bus.reg_wr_en  = 1'b0;
    bus.reg_dest   = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_opcode = 2'b00;
    bus.instr_done = 1'b0;
    bus.halted     = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 is computed every FETCH cycle but only committed with the IR.
        bus.mem_rd_en = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_wr_en  = bus.mem_ready;
        bus.pc_wr_en  = bus.mem_ready;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        bus.alu_src_b = 2'b11;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        bus.mem_rd_en = 1'b1;
        bus.i_or_d    = 1'b1;
      end
      S_MEM_WB: begin
        bus.reg_wr_en  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        // Strobe held for every wait cycle; memory commits on the ready one.
        bus.mem_wr_en  = 1'b1;
        bus.i_or_d     = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      S_R_EXEC: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_opcode = 2'b10;
      end
      S_R_WB: begin
        bus.reg_wr_en  = 1'b1;
        bus.reg_dest   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        bus.reg_wr_en  = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_opcode = 2'b01;
        bus.pc_src     = 2'b01;
        bus.branch_en  = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_JUMP: begin
        bus.pc_src     = 2'b10;
        bus.pc_wr_en   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_HALT: begin
        bus.halted = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.illegal_op = illegal_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl. Each cycle the bench sets mem_ready,
//   then compares the state and the full 19-bit control word against a
//   hand-written constant. Word bit order (MSB first):
//     pc_wr_en, branch_en, pc_src[1:0], ir_wr_en, i_or_d, mem_rd_en,
//     mem_wr_en, reg_wr_en, reg_dest, mem_to_reg, alu_src_a, alu_src_b[1:0],
//     alu_opcode[1:0], instr_done, halted, illegal_op
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  //                                  pw b ps  ir id rd wr rw rd m2 sa sb  ao  dn h  il
  localparam logic [18:0] W_IDLE   = 19'b0_0_00_0_0_0_0_0_0_0_0_00_00_0_0_0;
  localparam logic [18:0] W_F_RDY  = 19'b1_0_00_1_0_1_0_0_0_0_0_01_00_0_0_0;
  localparam logic [18:0] W_F_WAIT = 19'b0_0_00_0_0_1_0_0_0_0_0_01_00_0_0_0;
  localparam logic [18:0] W_DEC    = 19'b0_0_00_0_0_0_0_0_0_0_0_11_00_0_0_0;
  localparam logic [18:0] W_ADDR   = 19'b0_0_00_0_0_0_0_0_0_0_1_10_00_0_0_0;
  localparam logic [18:0] W_MRD    = 19'b0_0_00_0_1_1_0_0_0_0_0_00_00_0_0_0;
  localparam logic [18:0] W_MWB    = 19'b0_0_00_0_0_0_0_1_0_1_0_00_00_1_0_0;
  localparam logic [18:0] W_MWR_R  = 19'b0_0_00_0_1_0_1_0_0_0_0_00_00_1_0_0;
  localparam logic [18:0] W_MWR_W  = 19'b0_0_00_0_1_0_1_0_0_0_0_00_00_0_0_0;
  localparam logic [18:0] W_REX    = 19'b0_0_00_0_0_0_0_0_0_0_1_00_10_0_0_0;
  localparam logic [18:0] W_RWB    = 19'b0_0_00_0_0_0_0_1_1_0_0_00_00_1_0_0;
  localparam logic [18:0] W_AWB    = 19'b0_0_00_0_0_0_0_1_0_0_0_00_00_1_0_0;
  localparam logic [18:0] W_BEQ    = 19'b0_1_01_0_0_0_0_0_0_0_1_00_01_1_0_0;
  localparam logic [18:0] W_JMP    = 19'b1_0_10_0_0_0_0_0_0_0_0_00_00_1_0_0;
  localparam logic [18:0] W_HALT   = 19'b0_0_00_0_0_0_0_0_0_0_0_00_00_0_1_0;
  localparam logic [18:0] W_HALT_I = 19'b0_0_00_0_0_0_0_0_0_0_0_00_00_0_1_1;

  logic clk = 1'b0;
  logic rst_n;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle_n  = 0;
  int done_n   = 0;
  int cyc_start;
  int done_start;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] ctl_word();
    return {bus.pc_wr_en, bus.branch_en, bus.pc_src, bus.ir_wr_en, bus.i_or_d,
            bus.mem_rd_en, bus.mem_wr_en, bus.reg_wr_en, bus.reg_dest,
            bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_opcode,
            bus.instr_done, bus.halted, bus.illegal_op};
  endfunction

  // One clock cycle: apply mem_ready, sample mid-cycle, then advance.
  task automatic cyc(input string tag, input logic [3:0] exp_state,
                     input logic [18:0] exp_word, input logic ready);
    bus.mem_ready = ready;
    #1;
    check_eq({tag, "_state"}, {28'd0, bus.state}, {28'd0, exp_state});
    check_eq({tag, "_ctl"}, {13'd0, ctl_word()}, {13'd0, exp_word});
    if (bus.instr_done === 1'b1) done_n++;
    cycle_n++;
    @(posedge clk);
    #2;
  endtask

  task automatic begin_instr(input logic [5:0] op);
    bus.opcode = op;
    cyc_start  = cycle_n;
    done_start = done_n;
  endtask

  task automatic end_instr(input string tag, input int exp_cycles, input int exp_done);
    check_eq({tag, "_cycles"}, cycle_n - cyc_start, exp_cycles);
    check_eq({tag, "_retires"}, done_n - done_start, exp_done);
    $display("instr %s: opcode=%b cycles=%0d retires=%0d", tag, bus.opcode,
             cycle_n - cyc_start, done_n - done_start);
  endtask

  task automatic reset_edge();
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic start_run();
    bus.run = 1'b1;
    cyc("idle_run", 4'd0, W_IDLE, 1'b1);
    bus.run = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.run       = 1'b0;
    bus.opcode    = 6'b000000;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Reset state and run sampling: stays idle while run=0.
    cyc("reset", 4'd0, W_IDLE, 1'b1);
    cyc("idle_hold", 4'd0, W_IDLE, 1'b1);
    start_run();

    // R-type, zero wait states
    begin_instr(6'b000000);
    cyc("r_fetch", 4'd1, W_F_RDY, 1'b1);
    cyc("r_dec",   4'd2, W_DEC,   1'b1);
    cyc("r_exec",  4'd7, W_REX,   1'b1);
    cyc("r_wb",    4'd8, W_RWB,   1'b1);
    end_instr("rtype", 4, 1);

    // lw with three wait cycles in MEM_READ
    begin_instr(6'b100011);
    cyc("lw_fetch", 4'd1, W_F_RDY, 1'b1);
    cyc("lw_dec",   4'd2, W_DEC,   1'b1);
    cyc("lw_addr",  4'd3, W_ADDR,  1'b1);
    for (int i = 0; i < 3; i++) cyc("lw_wait", 4'd4, W_MRD, 1'b0);
    cyc("lw_rd",    4'd4, W_MRD,   1'b1);
    cyc("lw_wb",    4'd5, W_MWB,   1'b1);
    end_instr("lw", 8, 1);

    // sw, zero wait states
    begin_instr(6'b101011);
    cyc("sw_fetch", 4'd1, W_F_RDY, 1'b1);
    cyc("sw_dec",   4'd2, W_DEC,   1'b1);
    cyc("sw_addr",  4'd3, W_ADDR,  1'b1);
    cyc("sw_wr",    4'd6, W_MWR_R, 1'b1);
    end_instr("sw", 4, 1);

    // sw with one wait cycle: strobe held, retire only on ready
    begin_instr(6'b101011);
    cyc("sww_fetch", 4'd1, W_F_RDY, 1'b1);
    cyc("sww_dec",   4'd2, W_DEC,   1'b1);
    cyc("sww_addr",  4'd3, W_ADDR,  1'b1);
    cyc("sww_wait",  4'd6, W_MWR_W, 1'b0);
    cyc("sww_wr",    4'd6, W_MWR_R, 1'b1);
    end_instr("sw_wait", 5, 1);

    // addi with two fetch wait cycles: no PC/IR write while waiting
    begin_instr(6'b001000);
    cyc("addi_fwait", 4'd1, W_F_WAIT, 1'b0);
    cyc("addi_fwait", 4'd1, W_F_WAIT, 1'b0);
    cyc("addi_fetch", 4'd1, W_F_RDY,  1'b1);
    cyc("addi_dec",   4'd2, W_DEC,    1'b1);
    cyc("addi_exec",  4'd9, W_ADDR,   1'b1);
    cyc("addi_wb",    4'd10, W_AWB,   1'b1);
    end_instr("addi", 6, 1);

    // beq then j
    begin_instr(6'b000100);
    cyc("beq_fetch", 4'd1, W_F_RDY, 1'b1);
    cyc("beq_dec",   4'd2, W_DEC,   1'b1);
    cyc("beq_br",    4'd11, W_BEQ,  1'b1);
    end_instr("beq", 3, 1);

    begin_instr(6'b000010);
    cyc("j_fetch", 4'd1, W_F_RDY, 1'b1);
    cyc("j_dec",   4'd2, W_DEC,   1'b1);
    cyc("j_jmp",   4'd12, W_JMP,  1'b1);
    end_instr("j", 3, 1);

    // Legal halt opcode: halted without illegal_op, no retire pulse
    begin_instr(6'b111111);
    cyc("halt_fetch", 4'd1, W_F_RDY, 1'b1);
    cyc("halt_dec",   4'd2, W_DEC,   1'b1);
    for (int i = 0; i < 4; i++) cyc("halt_hold", 4'd13, W_HALT, i[0]);
    end_instr("halt", 6, 0);

    // Reset out of HALT, then reset in the middle of a memory read
    reset_edge();
    cyc("rst_from_halt", 4'd0, W_IDLE, 1'b1);
    start_run();
    begin_instr(6'b100011);
    cyc("mid_fetch", 4'd1, W_F_RDY, 1'b1);
    cyc("mid_dec",   4'd2, W_DEC,   1'b1);
    cyc("mid_addr",  4'd3, W_ADDR,  1'b1);
    bus.mem_ready = 1'b0;
    #1;
    check_eq("mid_rd_state", {28'd0, bus.state}, 32'd4);
    reset_edge();
    cyc("mid_rst", 4'd0, W_IDLE, 1'b0);

    // Illegal opcode: sticky illegal_op, no strobes for 20 cycles
    start_run();
    begin_instr(6'b010101);
    cyc("ill_fetch", 4'd1, W_F_RDY, 1'b1);
    cyc("ill_dec",   4'd2, W_DEC,   1'b1);
    for (int i = 0; i < 20; i++) cyc("ill_hold", 4'd13, W_HALT_I, i[0]);
    end_instr("illegal", 22, 0);
    reset_edge();
    cyc("ill_rst", 4'd0, W_IDLE, 1'b1);

    // Memory never ready in FETCH
    start_run();
    begin_instr(6'b000000);
`ifdef MC_MEM_TIMEOUT_EN
    for (int i = 0; i < 16; i++) cyc("to_wait", 4'd1, W_F_WAIT, 1'b0);
    cyc("to_halt", 4'd13, W_HALT_I, 1'b0);
    end_instr("timeout", 17, 0);
`else
    for (int i = 0; i < 100; i++) cyc("nto_wait", 4'd1, W_F_WAIT, 1'b0);
    cyc("nto_still", 4'd1, W_F_WAIT, 1'b0);
    end_instr("no_timeout", 101, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
